// File: rtl/riscv_types.sv
// Shared RISC-V core types: load/store size encoding and the data-memory
// responder's captured request and FSM state.
package riscv_types;

  typedef enum logic [1:0] {
    STORE_BYTE = 2'd0,
    STORE_HALF = 2'd1,
    STORE_WORD = 2'd2,
    STORE_RSVD = 2'd3
  } store_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    store_t      size;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef enum logic [1:0] {
    DM_IDLE,
    DM_ACCESS,
    DM_RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store strobes and replicated write
// data, right-justified load data, and natural-alignment checking.
module dmem_lane_align
  import riscv_types::*;
(
  input  store_t      size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raw_word_i,
  output logic [3:0]  strb_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] shifted;

  // The reserved size gets no strobes; the top flags it as an error.
  always_comb begin
    shifted     = raw_word_i >> {lane_i, 3'b000};
    strb_o      = 4'b0000;
    wdata_rep_o = wdata_i;
    rdata_o     = 32'h0;
    misalign_o  = 1'b0;
    case (size_i)
      STORE_BYTE: begin
        strb_o      = 4'b0001 << lane_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        rdata_o     = {24'h0, shifted[7:0]};
      end
      STORE_HALF: begin
        strb_o      = 4'b0011 << lane_i;
        wdata_rep_o = {2{wdata_i[15:0]}};
        rdata_o     = {16'h0, shifted[15:0]};
        misalign_o  = lane_i[0];
      end
      STORE_WORD: begin
        strb_o      = 4'b1111;
        rdata_o     = shifted;
        misalign_o  = |lane_i;
      end
      default: begin
        strb_o      = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/n_bit_reg.sv
// Generic N-bit register with write enable and asynchronous active-low clear.
module n_bit_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wen,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (wen) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core load/store port: one request at a time,
// WAIT_CYCLES extra access cycles, lane-aligned response with an error flag.
module dmem_responder
  import riscv_types::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  dmem_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  dmem_req_t   req_in, req_q;
  logic        accept;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0] raw_word;
  logic [3:0]  strb;
  logic [31:0] wdata_rep;
  logic [31:0] aligned_rdata;
  logic        misalign;
  logic        out_of_range;
  logic        err_now;
  logic        op_fire;
  logic        do_write;

  // Ready is gated by reset_n so nothing is offered while reset is held.
  assign req_ready = reset_n && (state_q == DM_IDLE);
  assign rsp_valid = (state_q == DM_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid && req_ready;

  assign req_in = '{addr: req_addr, we: req_we, size: store_t'(req_size), wdata: req_wdata};

  n_bit_reg #(.N($bits(dmem_req_t))) u_req_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .wen     (accept),
    .d       (req_in),
    .q       (req_q)
  );

  assign word_idx     = req_q.addr[AW+1:2];
  assign raw_word     = mem_q[word_idx];
  assign out_of_range = |req_q.addr[31:AW+2];
  assign err_now      = (req_q.size == STORE_RSVD) || misalign || out_of_range;
  assign op_fire      = (state_q == DM_ACCESS) && (cnt_q == 4'd0);
  assign do_write     = op_fire && req_q.we && !err_now;

  dmem_lane_align u_lane_align (
    .size_i      (req_q.size),
    .lane_i      (req_q.addr[1:0]),
    .wdata_i     (req_q.wdata),
    .raw_word_i  (raw_word),
    .strb_o      (strb),
    .wdata_rep_o (wdata_rep),
    .rdata_o     (aligned_rdata),
    .misalign_o  (misalign)
  );

  // The array has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DM_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      DM_IDLE: begin
        if (accept) begin
          state_d = DM_ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      DM_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DM_RESP;
          err_d   = err_now;
          rdata_d = (err_now || req_q.we) ? 32'h0 : aligned_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DM_RESP: begin
        if (rsp_ready) begin
          state_d = DM_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = DM_IDLE;
      end
    endcase
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the core's load/store port. It accepts one request at a time over a valid/ready handshake. It performs byte, halfword or word access into an internal word-organised SRAM, with a configurable number of wait states. The response carries right-justified read data or an error flag. Sign/zero extension of load data stays in the core's MEM stage; this block only aligns lanes.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, >= 2).
WAIT_CYCLES, 1, extra access cycles inserted before the response (0..15).

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_addr  input  32  byte address.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  store_t encoding: 0 byte, 1 halfword, 2 word, 3 reserved.
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
rsp_valid  output  1  response present.
rsp_ready  input  1  requester accepts the response.
rsp_rdata  output  32  load data, right-justified, upper bits zero; 0 for stores and errors.
rsp_err  output  1  access was misaligned, reserved-size, or out of range.

Behaviour:
- Reset: async assert → state IDLE; req_ready=0 while reset_n=0 and 1 in the first cycle after release.
  - Also reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - SRAM contents are not reset and are preserved across reset.
- FSM states IDLE, ACCESS, RESP.
- IDLE: req_ready=1. Handshake req_valid&req_ready at an edge captures addr/we/size/wdata and goes to ACCESS with counter=WAIT_CYCLES.
- ACCESS: req_ready=0.
  - Counter decrements each cycle.
  - On the cycle the counter is 0, the array operation occurs at that edge, the response is latched, and the state moves to RESP.
  - ACCESS therefore lasts WAIT_CYCLES+1 cycles. rsp_valid rises WAIT_CYCLES+1 edges after the accepting edge.
- RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid&rsp_ready at an edge.
  - That edge returns the state to IDLE.
  - No same-cycle re-accept: req_ready is 0 throughout RESP. Minimum request spacing is WAIT_CYCLES+3 cycles with rsp_ready tied high.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; lane = addr[1:0].
- Error conditions (any one sets rsp_err=1, suppresses the write, forces rsp_rdata=0):
  - size=3;
  - size=1 with addr[0]=1;
  - size=2 with addr[1:0]!=0;
  - addr >= 4*DEPTH_WORDS.
- Store write strobes:
  - byte → 4'b0001<<lane;
  - half → 4'b0011<<lane;
  - word → 4'b1111.
  - Data is replicated across lanes: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}.
  - Only strobed bytes change.
- Load data: word>>(8*lane), masked to 8/16/32 bits by size.
- rsp_rdata=0 and rsp_err=0 for a successful store.
- req_* inputs are ignored outside IDLE. Changes on req_* after acceptance do not affect the in-flight access.
- Reset asserted in ACCESS before the operation edge: the access is discarded and no write occurs. Reset in RESP drops the response.
- rsp_ready held low indefinitely: the responder stalls in RESP, and the array is untouched.

Decomposition:
- Add to riscv_types:
  - typedef struct packed dmem_req_t {addr[31:0], we, store_t size, wdata[31:0]} for the captured request;
  - typedef enum logic [1:0] {DM_IDLE, DM_ACCESS, DM_RESP} dmem_state_t.
- Widen store_t usage: reserved code 3 is named STORE_RSVD.
- One combinational sub-module, dmem_lane_align: inputs size, addr[1:0], wdata, raw word; outputs strobes[3:0], replicated wdata, aligned rdata, misalign flag.
- The captured request uses n_bit_reg with wen = handshake.

Test Plan:
1. WAIT_CYCLES=1; store word 0xDEADBEEF @0x10, then load word @0x10, rsp_ready=1 → rsp_valid 2 edges after accept; load returns 0xDEADBEEF, err=0.
2. Store byte 0x5A @0x11 over 0xDEADBEEF, then load word @0x10 → 0xDEAD5AEF; load byte @0x11 → 0x0000005A; load half @0x12 → 0x0000DEAD.
3. Store half @0x13, load word @0x06, size=3 @0x0, addr=0x1000 (DEPTH 1024) → each rsp_err=1, rdata=0; a subsequent load @0x10 shows the word unchanged.
4. rsp_ready=0 for 10 cycles after rsp_valid → rsp_rdata/rsp_err stable, req_ready=0 throughout; req_valid pulses ignored; on rsp_ready=1, IDLE next cycle.
5. WAIT_CYCLES=0 and WAIT_CYCLES=4 → rsp_valid 1 and 5 edges after accept respectively; back-to-back spacing 3 and 7 cycles.
6. Store word 0x12345678 @0x20 with reset_n pulsed low during ACCESS → after reset req_ready=1, rsp_valid=0; a load @0x20 returns the prior contents.
